qtz_level_stream: RTL and testbench

QTZ_LEVEL_STREAM -- requirements
Module: qtz_level_stream

---
 rtl/qtz_level_stream.sv | 139 +++++++++++++
 tb/tb_qtz_level_stream.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/qtz_level_stream.sv
// Streams a quantized level hypervector (hv1 below the split, hv0 above) as CHUNK_W beats.
// Optional sticky out-of-range flag: define QTZ_LEVEL_ERR_EN.
module qtz_level_stream #(
    parameter int HV_DIM     = 4096,
    parameter int NUM_LEVELS = 8,
    parameter int CHUNK_W    = 512,
    localparam int NUM_CHUNKS = HV_DIM / CHUNK_W,
    localparam int QW = $clog2(NUM_LEVELS + 1) + 1,
    localparam int IW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [QW-1:0]      req_qlevel,
    input  logic [HV_DIM-1:0]  base_hv0,
    input  logic [HV_DIM-1:0]  base_hv1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CHUNK_W-1:0] out_data,
    output logic [IW-1:0]      out_idx,
    output logic               out_last,
    output logic               busy,
    output logic               err
);

    localparam int SW  = $clog2(HV_DIM + 1);
    localparam int SEG = HV_DIM / NUM_LEVELS;

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [QW-1:0]      r_level;
    logic [IW-1:0]      r_idx;
    logic               w_accept;
    logic               w_beat;
    logic               w_last;
    logic               w_over;
    logic [QW-1:0]      w_qclamp;
    logic [SW-1:0]      w_split;
    logic [SW-1:0]      w_base;
    logic [CHUNK_W-1:0] w_hv0_c;
    logic [CHUNK_W-1:0] w_hv1_c;

    assign w_over   = req_qlevel > QW'(NUM_LEVELS);
    assign w_qclamp = w_over ? QW'(NUM_LEVELS) : req_qlevel;
    assign w_last   = (r_idx == IW'(NUM_CHUNKS - 1));

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        w_beat      = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    w_beat = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_level <= w_qclamp;
            r_idx   <= '0;
        end else if (w_beat) begin
            r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
    end

    // Bits below the split come from hv1, the rest from hv0.
    assign w_split = SW'(SEG) * (SW'(NUM_LEVELS) - SW'(r_level));
    assign w_base  = SW'(r_idx) * SW'(CHUNK_W);
    assign w_hv0_c = base_hv0[w_base +: CHUNK_W];
    assign w_hv1_c = base_hv1[w_base +: CHUNK_W];

    always_comb begin
        out_data = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            if ((w_base + SW'(i)) >= w_split) begin
                out_data[i] = w_hv0_c[i];
            end else begin
                out_data[i] = w_hv1_c[i];
            end
        end
    end

    assign out_idx  = r_idx;
    assign out_last = (r_state == S_STREAM) && w_last;

`ifdef QTZ_LEVEL_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_accept && w_over) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_qtz_level_stream.sv
// Directed, table-driven bench for qtz_level_stream at default parameters.
// Expected err follows QTZ_LEVEL_ERR_EN when defined for the bench build.
module tb_qtz_level_stream;

    localparam int HV = 4096;
    localparam int NL = 8;
    localparam int CW = 512;
    localparam int NC = HV / CW;

`ifdef QTZ_LEVEL_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [4:0]    req_qlevel;
    logic [HV-1:0] base_hv0;
    logic [HV-1:0] base_hv1;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_data;
    logic [2:0]    out_idx;
    logic          out_last;
    logic          busy;
    logic          err;

    int checks   = 0;
    int failures = 0;

    qtz_level_stream dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_qlevel(req_qlevel),
        .base_hv0  (base_hv0),
        .base_hv1  (base_hv1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        int split;
        bit rnd;
        int stall_k;
        int stall_n;
        bit err_after;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [CW-1:0] act,
                       input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] exp_chunk(input int split, input int k);
        logic [CW-1:0] c;
        for (int i = 0; i < CW; i++) begin
            c[i] = ((k * CW + i) >= split) ? base_hv0[k*CW+i] : base_hv1[k*CW+i];
        end
        return c;
    endfunction

    task automatic rand_hv();
        for (int w = 0; w < HV / 32; w++) begin
            base_hv0[w*32 +: 32] = $urandom;
            base_hv1[w*32 +: 32] = $urandom;
        end
    endtask

    task automatic start_req(input int q);
        chk("idle_ready", {511'd0, req_ready}, 1);
        chk("idle_busy", {511'd0, busy}, 0);
        req_valid  = 1'b1;
        req_qlevel = 5'(q);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic beats(input int split, input int stall_k, input int stall_n,
                         input bit hold, input int hold_q);
        if (hold) begin
            req_valid  = 1'b1;
            req_qlevel = 5'(hold_q);
        end
        for (int k = 0; k < NC; k++) begin
            chk("beat_valid", {511'd0, out_valid}, 1);
            chk("beat_idx", {509'd0, out_idx}, CW'(k));
            chk("beat_data", out_data, exp_chunk(split, k));
            chk("beat_last", {511'd0, out_last}, CW'(k == NC - 1));
            chk("beat_rdy_low", {511'd0, req_ready}, 0);
            if (k == stall_k) begin
                out_ready = 1'b0;
                repeat (stall_n) begin
                    @(negedge clk);
                    chk("stall_idx", {509'd0, out_idx}, CW'(k));
                    chk("stall_data", out_data, exp_chunk(split, k));
                    chk("stall_valid", {511'd0, out_valid}, 1);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("end_valid", {511'd0, out_valid}, 0);
        chk("end_ready", {511'd0, req_ready}, 1);
        chk("end_busy", {511'd0, busy}, 0);
    endtask

    initial begin
        vecs[0] = '{q: 3,  split: 2560, rnd: 0, stall_k: -1, stall_n: 0, err_after: 0};
        vecs[1] = '{q: 0,  split: 4096, rnd: 1, stall_k: -1, stall_n: 0, err_after: 0};
        vecs[2] = '{q: 8,  split: 0,    rnd: 1, stall_k: -1, stall_n: 0, err_after: 0};
        vecs[3] = '{q: 5,  split: 1536, rnd: 1, stall_k: 2,  stall_n: 3, err_after: 0};
        vecs[4] = '{q: 12, split: 0,    rnd: 1, stall_k: -1, stall_n: 0, err_after: ERR_ON};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_qlevel = '0;
        out_ready  = 1'b1;
        base_hv0   = '1;
        base_hv1   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {511'd0, req_ready}, 1);
        chk("rst_valid", {511'd0, out_valid}, 0);
        chk("rst_idx", {509'd0, out_idx}, 0);
        chk("rst_last", {511'd0, out_last}, 0);
        chk("rst_busy", {511'd0, busy}, 0);
        chk("rst_err", {511'd0, err}, 0);

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].rnd) rand_hv();
            else begin
                base_hv0 = '1;
                base_hv1 = '0;
            end
            start_req(vecs[v].q);
            if (v == 0) begin
                chk("q3_beat0_zero", out_data, '0);
            end
            beats(vecs[v].split, vecs[v].stall_k, vecs[v].stall_n, 1'b0, 0);
            chk("vec_err", {511'd0, err}, CW'(vecs[v].err_after));
        end

        // Request held through a stream: picked up only after the last beat.
        rand_hv();
        start_req(1);
        beats(3584, -1, 0, 1'b1, 6);
        @(negedge clk);
        req_valid = 1'b0;
        beats(1024, -1, 0, 1'b0, 0);
        chk("err_persist", {511'd0, err}, CW'(ERR_ON));

        // Reset in the middle of a stream.
        start_req(3);
        repeat (4) @(negedge clk);
        chk("pre_rst_idx", {509'd0, out_idx}, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", {511'd0, out_valid}, 0);
        chk("mid_rst_ready", {511'd0, req_ready}, 1);
        chk("mid_rst_err", {511'd0, err}, 0);
        chk("mid_rst_idx", {509'd0, out_idx}, 0);
        start_req(5);
        beats(1536, -1, 0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
